bus_arbiter_mux: RTL and testbench

- Parametrised, registered successor to the datapath's fixed-priority four-source bus multiplexer.
- Selects one of N_SRC tri-state-free sources onto a shared WIDTH-bit DataBus.
- Supports a fixed-priority or round-robin policy, a bus-lock hold, and contention detection with a saturating error counter.
- Sits between the datapath register/ALU/MDR/MARMUX sources and all DataBus consumers.

---
 rtl/bus_arbiter_mux.sv | 186 ++++++++++++++++++
 tb/tb_bus_arbiter_mux.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_mux.sv
// Registered N-source DataBus arbiter/multiplexer with fixed-priority or round-robin
// selection, owner lock, idle policy and saturating contention accounting.
module bus_arbiter_mux #(
    parameter int WIDTH     = 16,
    parameter int N_SRC     = 4,
    parameter int MODE      = 0,
    parameter int IDLE_HOLD = 0,
    parameter int CNT_W     = 8
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic [N_SRC*WIDTH-1:0]   src_data,
    input  logic [N_SRC-1:0]         src_en,
    input  logic                     lock,
    input  logic                     clr_err,
    output logic [WIDTH-1:0]         DataBus,
    output logic                     bus_valid,
    output logic [N_SRC-1:0]         grant,
    output logic                     contention,
    output logic                     err_sticky,
    output logic [CNT_W-1:0]         cont_cnt
);

    localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    // Indexed word select out of the packed source vector.
    function automatic logic [WIDTH-1:0] pick_data(input logic [N_SRC*WIDTH-1:0] data,
                                                   input logic [PTR_W-1:0]       idx);
        logic [WIDTH-1:0] res;
        res = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (idx == PTR_W'(i)) begin
                res = data[i*WIDTH +: WIDTH];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // One-hot decode of a source index.
    function automatic logic [N_SRC-1:0] to_onehot(input logic [PTR_W-1:0] idx);
        logic [N_SRC-1:0] res;
        res = '0;
        for (int i = 0; i < N_SRC; i++) begin
            res[i] = (idx == PTR_W'(i));
        end
        return res;
    endfunction

    logic [WIDTH-1:0] data_q,  data_d;
    logic             valid_q, valid_d;
    logic [N_SRC-1:0] grant_q, grant_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             cont_q,  cont_d;
    logic             err_q,   err_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic             any_req_s;
    logic             multi_req_s;
    logic [PTR_W-1:0] fp_idx_s;
    logic [PTR_W:0]   cand_s;
    logic [PTR_W-1:0] rr_idx_s;
    logic             rr_found_s;
    logic             owner_hold_s;
    logic             sel_valid_s;
    logic [PTR_W-1:0] sel_idx_s;

    // Request summary: any request, more than one request, lowest-index requester.
    always_comb begin
        any_req_s   = 1'b0;
        multi_req_s = 1'b0;
        fp_idx_s    = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            multi_req_s = multi_req_s | (any_req_s & src_en[i]);
            any_req_s   = any_req_s | src_en[i];
            if (src_en[i]) begin
                fp_idx_s = PTR_W'(i);
            end else begin
                fp_idx_s = fp_idx_s;
            end
        end
    end

    // Round-robin search: first requester at or after rr_ptr, wrapping modulo N_SRC.
    always_comb begin
        cand_s     = '0;
        rr_idx_s   = '0;
        rr_found_s = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            cand_s = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (cand_s >= (PTR_W+1)'(N_SRC)) begin
                cand_s = cand_s - (PTR_W+1)'(N_SRC);
            end else begin
                cand_s = cand_s;
            end
            if (!rr_found_s && src_en[cand_s[PTR_W-1:0]]) begin
                rr_found_s = 1'b1;
                rr_idx_s   = cand_s[PTR_W-1:0];
            end else begin
                rr_found_s = rr_found_s;
            end
        end
    end

    // A lock only holds while a grant exists and its owner is still requesting.
    assign owner_hold_s = lock & (|(grant_q & src_en));

    // Winner selection and pointer advance; pointer freezes on locked and idle cycles.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_idx_s   = owner_q;
        rr_ptr_d    = rr_ptr_q;
        if (owner_hold_s) begin
            sel_valid_s = 1'b1;
            sel_idx_s   = owner_q;
        end else if (any_req_s) begin
            sel_valid_s = 1'b1;
            if (MODE == 1) begin
                sel_idx_s = rr_idx_s;
                rr_ptr_d  = (rr_idx_s == PTR_W'(N_SRC - 1)) ? '0 : rr_idx_s + PTR_W'(1);
            end else begin
                sel_idx_s = fp_idx_s;
            end
        end else begin
            sel_valid_s = 1'b0;
        end
    end

    // Output and status next-state; clear beats a same-cycle contention for the status.
    always_comb begin
        valid_d = sel_valid_s;
        cont_d  = multi_req_s;
        owner_d = sel_valid_s ? sel_idx_s : owner_q;
        grant_d = sel_valid_s ? to_onehot(sel_idx_s) : '0;
        if (sel_valid_s) begin
            data_d = pick_data(src_data, sel_idx_s);
        end else if (IDLE_HOLD != 0) begin
            data_d = data_q;
        end else begin
            data_d = '0;
        end
        if (clr_err) begin
            err_d = 1'b0;
            cnt_d = '0;
        end else if (multi_req_s) begin
            err_d = 1'b1;
            cnt_d = (cnt_q != {CNT_W{1'b1}}) ? cnt_q + CNT_W'(1) : cnt_q;
        end else begin
            err_d = err_q;
            cnt_d = cnt_q;
        end
    end

    // State and output registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            data_q   <= '0;
            valid_q  <= 1'b0;
            grant_q  <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cont_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            data_q   <= data_d;
            valid_q  <= valid_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cont_q   <= cont_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign DataBus    = data_q;
    assign bus_valid  = valid_q;
    assign grant      = grant_q;
    assign contention = cont_q;
    assign err_sticky = err_q;
    assign cont_cnt   = cnt_q;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Directed bench: instance a is fixed-priority/zero-idle/8-bit counter,
// instance b is round-robin/hold-idle/2-bit counter; both share the stimulus.
module tb_bus_arbiter_mux;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [63:0] src_data = 64'h0;
    logic [3:0]  src_en = 4'b0;
    logic        lock = 1'b0;
    logic        clr_err = 1'b0;

    logic [15:0] a_bus, b_bus;
    logic        a_valid, b_valid, a_cont, b_cont, a_err, b_err;
    logic [3:0]  a_grant, b_grant;
    logic [7:0]  a_cnt;
    logic [1:0]  b_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    bus_arbiter_mux #(.WIDTH(16), .N_SRC(4), .MODE(0), .IDLE_HOLD(0), .CNT_W(8)) dut_a (
        .Clk(Clk), .Reset_n(Reset_n), .src_data(src_data), .src_en(src_en), .lock(lock),
        .clr_err(clr_err), .DataBus(a_bus), .bus_valid(a_valid), .grant(a_grant),
        .contention(a_cont), .err_sticky(a_err), .cont_cnt(a_cnt));

    bus_arbiter_mux #(.WIDTH(16), .N_SRC(4), .MODE(1), .IDLE_HOLD(1), .CNT_W(2)) dut_b (
        .Clk(Clk), .Reset_n(Reset_n), .src_data(src_data), .src_en(src_en), .lock(lock),
        .clr_err(clr_err), .DataBus(b_bus), .bus_valid(b_valid), .grant(b_grant),
        .contention(b_cont), .err_sticky(b_err), .cont_cnt(b_cnt));

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic apply_reset();
        Reset_n = 1'b0; lock = 1'b0; clr_err = 1'b0; src_en = 4'b0000;
        #2;
        step();
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        src_data = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        src_en = 4'b1111;
        step();
        step();
        Reset_n = 1'b0;
        #2;
        n_cmp++; if (a_bus !== 16'h0000) begin n_bad++; $display("FAIL rst_bus_a: got %h expected %h", a_bus, 16'h0000); end
        n_cmp++; if (a_grant !== 4'b0000) begin n_bad++; $display("FAIL rst_grant_a: got %b expected %b", a_grant, 4'b0000); end
        n_cmp++; if (a_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid_a: got %b expected %b", a_valid, 1'b0); end
        n_cmp++; if (a_cnt !== 8'd0 || a_err !== 1'b0 || a_cont !== 1'b0) begin n_bad++; $display("FAIL rst_status_a: got cnt=%0d err=%b cont=%b expected 0 0 0", a_cnt, a_err, a_cont); end
        n_cmp++; if (b_bus !== 16'h0000 || b_grant !== 4'b0000 || b_cnt !== 2'd0) begin n_bad++; $display("FAIL rst_b: got bus=%h grant=%b cnt=%0d expected 0000 0000 0", b_bus, b_grant, b_cnt); end
        step();
        n_cmp++; if (a_grant !== 4'b0000) begin n_bad++; $display("FAIL rst_hold_grant: got %b expected %b", a_grant, 4'b0000); end
        Reset_n = 1'b1;
        step();
        n_cmp++; if (a_grant !== 4'b0001) begin n_bad++; $display("FAIL rst_first_grant_a: got %b expected %b", a_grant, 4'b0001); end
        n_cmp++; if (b_grant !== 4'b0001) begin n_bad++; $display("FAIL rst_first_grant_b: got %b expected %b", b_grant, 4'b0001); end
        n_cmp++; if (a_bus !== 16'hAAAA || a_valid !== 1'b1) begin n_bad++; $display("FAIL rst_first_data: got %h/%b expected aaaa/1", a_bus, a_valid); end
    endtask

    task automatic test_priority();
        apply_reset();
        src_data = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        src_en = 4'b1100;
        step();
        n_cmp++; if (a_bus !== 16'hCCCC) begin n_bad++; $display("FAIL prio_bus: got %h expected %h", a_bus, 16'hCCCC); end
        n_cmp++; if (a_grant !== 4'b0100) begin n_bad++; $display("FAIL prio_grant: got %b expected %b", a_grant, 4'b0100); end
        n_cmp++; if (a_cont !== 1'b1) begin n_bad++; $display("FAIL prio_cont: got %b expected %b", a_cont, 1'b1); end
        n_cmp++; if (a_cnt !== 8'd1) begin n_bad++; $display("FAIL prio_cnt: got %0d expected %0d", a_cnt, 1); end
        n_cmp++; if (a_err !== 1'b1) begin n_bad++; $display("FAIL prio_err: got %b expected %b", a_err, 1'b1); end
        src_en = 4'b1000;
        step();
        n_cmp++; if (a_grant !== 4'b1000 || a_bus !== 16'hDDDD) begin n_bad++; $display("FAIL prio_single: got %b/%h expected 1000/dddd", a_grant, a_bus); end
        n_cmp++; if (a_cont !== 1'b0 || a_cnt !== 8'd1 || a_err !== 1'b1) begin n_bad++; $display("FAIL prio_single_status: got cont=%b cnt=%0d err=%b expected 0 1 1", a_cont, a_cnt, a_err); end
        src_en = 4'b1010;
        step();
        n_cmp++; if (a_grant !== 4'b0010 || a_bus !== 16'hBBBB) begin n_bad++; $display("FAIL prio_low: got %b/%h expected 0010/bbbb", a_grant, a_bus); end
    endtask

    task automatic test_rotation();
        logic [3:0]  exp_g [4];
        logic [15:0] exp_d [4];
        logic [1:0]  exp_c [4];
        exp_g = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
        exp_d = '{16'hAAAA, 16'hBBBB, 16'hDDDD, 16'hAAAA};
        exp_c = '{2'd1, 2'd2, 2'd3, 2'd3};
        apply_reset();
        src_data = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        src_en = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if (b_grant !== exp_g[i] || b_bus !== exp_d[i]) begin n_bad++; $display("FAIL rr_cycle%0d: got %b/%h expected %b/%h", i, b_grant, b_bus, exp_g[i], exp_d[i]); end
            n_cmp++; if (b_cnt !== exp_c[i]) begin n_bad++; $display("FAIL rr_cnt%0d: got %0d expected %0d", i, b_cnt, exp_c[i]); end
        end
        n_cmp++; if (a_grant !== 4'b0001) begin n_bad++; $display("FAIL rr_fixed_a: got %b expected %b", a_grant, 4'b0001); end
    endtask

    task automatic test_lock();
        apply_reset();
        src_data = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        src_en = 4'b0011;
        step();
        step();
        n_cmp++; if (b_grant !== 4'b0010) begin n_bad++; $display("FAIL lock_setup: got %b expected %b", b_grant, 4'b0010); end
        lock = 1'b1;
        for (int i = 0; i < 3; i++) begin
            src_data[31:16] = 16'h5000 + 16'(i);
            step();
            n_cmp++; if (b_grant !== 4'b0010 || b_bus !== 16'h5000 + 16'(i)) begin n_bad++; $display("FAIL lock_hold%0d: got %b/%h expected 0010/%h", i, b_grant, b_bus, 16'h5000 + 16'(i)); end
        end
        n_cmp++; if (b_cont !== 1'b1 || b_cnt !== 2'd3) begin n_bad++; $display("FAIL lock_cont: got cont=%b cnt=%0d expected 1 3", b_cont, b_cnt); end
        src_en = 4'b0001;
        step();
        n_cmp++; if (b_grant !== 4'b0001) begin n_bad++; $display("FAIL lock_drop: got %b expected %b", b_grant, 4'b0001); end
        lock = 1'b0;
        src_en = 4'b1111;
        step();
        n_cmp++; if (b_grant !== 4'b0010) begin n_bad++; $display("FAIL lock_after: got %b expected %b", b_grant, 4'b0010); end
        apply_reset();
        lock = 1'b1;
        src_en = 4'b0100;
        step();
        n_cmp++; if (b_grant !== 4'b0100 || a_grant !== 4'b0100) begin n_bad++; $display("FAIL lock_nogrant: got %b/%b expected 0100/0100", b_grant, a_grant); end
    endtask

    task automatic test_idle();
        apply_reset();
        src_data = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'h1234};
        src_en = 4'b0001;
        step();
        n_cmp++; if (a_bus !== 16'h1234 || b_bus !== 16'h1234) begin n_bad++; $display("FAIL idle_pre: got %h/%h expected 1234/1234", a_bus, b_bus); end
        src_en = 4'b0000;
        step();
        n_cmp++; if (a_bus !== 16'h0000) begin n_bad++; $display("FAIL idle_zero: got %h expected %h", a_bus, 16'h0000); end
        n_cmp++; if (b_bus !== 16'h1234) begin n_bad++; $display("FAIL idle_hold: got %h expected %h", b_bus, 16'h1234); end
        n_cmp++; if (a_valid !== 1'b0 || b_valid !== 1'b0 || a_grant !== 4'b0000 || b_grant !== 4'b0000) begin n_bad++; $display("FAIL idle_valid: got %b %b %b %b expected 0 0 0000 0000", a_valid, b_valid, a_grant, b_grant); end
        src_en = 4'b1111;
        step();
        n_cmp++; if (b_grant !== 4'b0010) begin n_bad++; $display("FAIL idle_ptr: got %b expected %b", b_grant, 4'b0010); end
    endtask

    task automatic test_saturation_clear();
        apply_reset();
        src_en = 4'b0011;
        for (int i = 0; i < 5; i++) step();
        n_cmp++; if (b_cnt !== 2'd3 || b_err !== 1'b1) begin n_bad++; $display("FAIL sat_b: got cnt=%0d err=%b expected 3 1", b_cnt, b_err); end
        n_cmp++; if (a_cnt !== 8'd5) begin n_bad++; $display("FAIL sat_a: got %0d expected %0d", a_cnt, 5); end
        clr_err = 1'b1;
        step();
        n_cmp++; if (b_cnt !== 2'd0 || b_err !== 1'b0 || b_cont !== 1'b1) begin n_bad++; $display("FAIL clr_b: got cnt=%0d err=%b cont=%b expected 0 0 1", b_cnt, b_err, b_cont); end
        n_cmp++; if (a_cnt !== 8'd0 || a_err !== 1'b0 || a_cont !== 1'b1) begin n_bad++; $display("FAIL clr_a: got cnt=%0d err=%b cont=%b expected 0 0 1", a_cnt, a_err, a_cont); end
        clr_err = 1'b0;
        src_en = 4'b0001;
        step();
        n_cmp++; if (a_cont !== 1'b0 || a_cnt !== 8'd0 || a_err !== 1'b0) begin n_bad++; $display("FAIL clr_quiet: got cont=%b cnt=%0d err=%b expected 0 0 0", a_cont, a_cnt, a_err); end
        src_en = 4'b0011;
        step();
        n_cmp++; if (a_cnt !== 8'd1 || a_err !== 1'b1) begin n_bad++; $display("FAIL clr_recount: got cnt=%0d err=%b expected 1 1", a_cnt, a_err); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        src_data = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        src_en = 4'b0011;
        step();
        step();
        lock = 1'b1;
        step();
        n_cmp++; if (b_grant !== 4'b0010) begin n_bad++; $display("FAIL b2b_locked: got %b expected %b", b_grant, 4'b0010); end
        Reset_n = 1'b0;
        #2;
        n_cmp++; if (b_grant !== 4'b0000 || b_bus !== 16'h0000 || b_cont !== 1'b0) begin n_bad++; $display("FAIL b2b_async: got %b/%h/%b expected 0000/0000/0", b_grant, b_bus, b_cont); end
        step();
        Reset_n = 1'b1;
        step();
        n_cmp++; if (b_grant !== 4'b0001 || b_bus !== 16'hAAAA) begin n_bad++; $display("FAIL b2b_nolock: got %b/%h expected 0001/aaaa", b_grant, b_bus); end
        n_cmp++; if (b_cnt !== 2'd1) begin n_bad++; $display("FAIL b2b_cnt: got %0d expected %0d", b_cnt, 1); end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_rotation();
        test_lock();
        test_idle();
        test_saturation_clear();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
